// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline.
// Drives PC/IF-ID enables, IF/ID flush, freeze, bubble select and perf counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_BUBBLES   = 1,
  parameter int BRANCH_BUBBLES = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           id_rn,
  input  logic [3:0]           id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_uses_rm,
  input  logic [3:0]           ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  input  logic                 cnt_clear,
  output logic                 cu_bubble,
  output logic                 pc_enable,
  output logic                 if_id_enable,
  output logic                 if_id_flush,
  output logic                 pipe_freeze,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] LU_M1 = 2'(LOAD_BUBBLES - 1);
  localparam logic [1:0] BR_M1 = 2'(BRANCH_BUBBLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;
  logic                 lu;

  // R15 (PC) is never forwarded from a load, so never a hazard
  assign lu = ex_mem_read && (ex_rd != 4'hF) &&
              ((id_uses_rn && (id_rn == ex_rd)) ||
               (id_uses_rm && (id_rm == ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    cu_bubble    = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      cu_bubble    = 1'b1;
    end else if (mem_busy) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      pipe_freeze  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            cu_bubble   = 1'b1;
            if (BRANCH_BUBBLES > 1) begin
              state_d = BR_FLUSH;
              cnt_d   = BR_M1;
            end
          end else if (lu) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            cu_bubble    = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_M1;
            end
          end
        end
        LU_STALL: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          cu_bubble    = 1'b1;
          cnt_d        = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        BR_FLUSH: begin
          if_id_flush = 1'b1;
          cu_bubble   = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cnt_clear) begin
        stall_q <= '0;
        flush_q <= '0;
      end else begin
        if (!pc_enable && (stall_q != '1))
          stall_q <= stall_q + 1'b1;
        if (if_id_flush && (flush_q != '1))
          flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven in parallel,
// checked every cycle against a remaining-bubble-count model.
module tb_pipeline_hazard_ctrl;

  localparam int LB0 = 3, BB0 = 2, CW0 = 4;
  localparam int LB1 = 1, BB1 = 1, CW1 = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm;
  logic       ex_mem_read, branch_taken;
  logic       mem_busy, cnt_clear;

  logic        pc[2], ife[2], bub[2], fl[2], fr[2];
  logic [CW0-1:0] sc0, fc0;
  logic [CW1-1:0] sc1, fc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .LOAD_BUBBLES(LB0), .BRANCH_BUBBLES(BB0), .CNT_WIDTH(CW0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear),
    .cu_bubble(bub[0]), .pc_enable(pc[0]),
    .if_id_enable(ife[0]), .if_id_flush(fl[0]),
    .pipe_freeze(fr[0]),
    .stall_count(sc0), .flush_count(fc0)
  );

  pipeline_hazard_ctrl #(
    .LOAD_BUBBLES(LB1), .BRANCH_BUBBLES(BB1), .CNT_WIDTH(CW1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clear(cnt_clear),
    .cu_bubble(bub[1]), .pc_enable(pc[1]),
    .if_id_enable(ife[1]), .if_id_flush(fl[1]),
    .pipe_freeze(fr[1]),
    .stall_count(sc1), .flush_count(fc1)
  );

  int lbp[2]  = '{LB0, LB1};
  int bbp[2]  = '{BB0, BB1};
  int maxc[2] = '{(1 << CW0) - 1, (1 << CW1) - 1};

  int rem_lu[2], rem_br[2], m_sc[2], m_fc[2];
  int n_lu[2], n_br[2], n_sc[2], n_fc[2];
  logic e_pc[2], e_ife[2], e_bub[2], e_fl[2], e_fr[2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_o(input int k, input logic p, input logic f,
                       input logic b, input logic x, input logic z);
    e_pc[k]  = p;
    e_ife[k] = f;
    e_bub[k] = b;
    e_fl[k]  = x;
    e_fr[k]  = z;
  endtask

  task automatic model_eval();
    logic lu;
    lu = ex_mem_read && (ex_rd != 4'hF) &&
         ((id_uses_rn && id_rn == ex_rd) ||
          (id_uses_rm && id_rm == ex_rd));
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem_lu[k] = 0;
        rem_br[k] = 0;
        m_sc[k]   = 0;
        m_fc[k]   = 0;
      end
      n_lu[k] = rem_lu[k];
      n_br[k] = rem_br[k];
      if (!rst_n) set_o(k, 0, 0, 1, 0, 0);
      else if (mem_busy) set_o(k, 0, 0, 0, 0, 1);
      else if (rem_lu[k] > 0) begin
        set_o(k, 0, 0, 1, 0, 0);
        n_lu[k] = rem_lu[k] - 1;
      end else if (rem_br[k] > 0) begin
        set_o(k, 1, 1, 1, 1, 0);
        n_br[k] = rem_br[k] - 1;
      end else if (branch_taken) begin
        set_o(k, 1, 1, 1, 1, 0);
        n_br[k] = bbp[k] - 1;
      end else if (lu) begin
        set_o(k, 0, 0, 1, 0, 0);
        n_lu[k] = lbp[k] - 1;
      end else set_o(k, 1, 1, 0, 0, 0);
      if (!rst_n || cnt_clear) begin
        n_sc[k] = 0;
        n_fc[k] = 0;
      end else begin
        n_sc[k] = m_sc[k] + (e_pc[k] ? 0 : 1);
        n_fc[k] = m_fc[k] + (e_fl[k] ? 1 : 0);
        if (n_sc[k] > maxc[k]) n_sc[k] = maxc[k];
        if (n_fc[k] > maxc[k]) n_fc[k] = maxc[k];
      end
    end
  endtask

  task automatic compare();
    chk("u0.pc_enable",    int'(pc[0]),  int'(e_pc[0]));
    chk("u0.if_id_enable", int'(ife[0]), int'(e_ife[0]));
    chk("u0.cu_bubble",    int'(bub[0]), int'(e_bub[0]));
    chk("u0.if_id_flush",  int'(fl[0]),  int'(e_fl[0]));
    chk("u0.pipe_freeze",  int'(fr[0]),  int'(e_fr[0]));
    chk("u0.stall_count",  int'(sc0),    m_sc[0]);
    chk("u0.flush_count",  int'(fc0),    m_fc[0]);
    chk("u1.pc_enable",    int'(pc[1]),  int'(e_pc[1]));
    chk("u1.if_id_enable", int'(ife[1]), int'(e_ife[1]));
    chk("u1.cu_bubble",    int'(bub[1]), int'(e_bub[1]));
    chk("u1.if_id_flush",  int'(fl[1]),  int'(e_fl[1]));
    chk("u1.pipe_freeze",  int'(fr[1]),  int'(e_fr[1]));
    chk("u1.stall_count",  int'(sc1),    m_sc[1]);
    chk("u1.flush_count",  int'(fc1),    m_fc[1]);
  endtask

  task automatic cyc(input logic r, input logic mb, input logic br,
                     input logic mr, input logic [3:0] rd,
                     input logic [3:0] rn, input logic [3:0] rm,
                     input logic urn, input logic urm, input logic cl);
    rst_n        = r;
    mem_busy     = mb;
    branch_taken = br;
    ex_mem_read  = mr;
    ex_rd        = rd;
    id_rn        = rn;
    id_rm        = rm;
    id_uses_rn   = urn;
    id_uses_rm   = urm;
    cnt_clear    = cl;
    #1;
    model_eval();
    compare();
  endtask

  task automatic nxt();
    for (int k = 0; k < 2; k++) begin
      rem_lu[k] = n_lu[k];
      rem_br[k] = n_br[k];
      m_sc[k]   = n_sc[k];
      m_fc[k]   = n_fc[k];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0);
  endtask

  task automatic lu_in();
    cyc(1, 0, 0, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0);
  endtask

  task automatic busy(input logic cl);
    cyc(1, 1, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, cl);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rem_lu[k] = 0; rem_br[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    @(negedge clk);
    cyc(0, 1, 1, 1, 4'd3, 4'd3, 4'd3, 1, 1, 0);
    chk("rst_pc", int'(pc[0]), 0);
    chk("rst_bub", int'(bub[0]), 1);
    chk("rst_freeze", int'(fr[0]), 0);
    chk("rst_sc", int'(sc0), 0);
    nxt();
    idle();
    chk("rel_pc", int'(pc[0]), 1);
    nxt();

    lu_in();
    chk("lu1_bub", int'(bub[0]), 1);
    chk("lu1_pc", int'(pc[0]), 0);
    nxt();
    idle();
    chk("lu2_bub", int'(bub[0]), 1);
    chk("lu2_u1_pc", int'(pc[1]), 1);
    nxt();
    idle();
    chk("lu3_bub", int'(bub[0]), 1);
    nxt();
    idle();
    chk("lu4_pc", int'(pc[0]), 1);
    chk("lu_sc0", int'(sc0), 3);
    chk("lu_sc1", int'(sc1), 1);
    nxt();

    lu_in();
    nxt();
    cyc(0, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 0);
    chk("rm_bub", int'(bub[0]), 1);
    chk("rm_pc", int'(pc[0]), 0);
    chk("rm_flush", int'(fl[0]), 0);
    nxt();
    idle();
    chk("rm_rel_pc", int'(pc[0]), 1);
    chk("rm_rel_sc", int'(sc0), 0);
    nxt();
    idle();
    chk("rm_nores_pc", int'(pc[0]), 1);
    nxt();

    cyc(1, 0, 0, 1, 4'hF, 4'hF, 4'd0, 1, 0, 0);
    chk("r15_pc", int'(pc[0]), 1);
    nxt();
    cyc(1, 0, 0, 1, 4'd5, 4'd5, 4'd5, 0, 0, 0);
    chk("nouse_pc", int'(pc[0]), 1);
    nxt();

    cyc(1, 0, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0, 0);
    chk("br1_fl", int'(fl[0]), 1);
    chk("br1_pc", int'(pc[0]), 1);
    chk("br1_bub", int'(bub[0]), 1);
    nxt();
    idle();
    chk("br2_fl", int'(fl[0]), 1);
    chk("br2_u1_fl", int'(fl[1]), 0);
    nxt();
    idle();
    chk("br3_fl", int'(fl[0]), 0);
    chk("br_fc0", int'(fc0), 2);
    chk("br_sc0", int'(sc0), 0);
    chk("br_fc1", int'(fc1), 1);
    nxt();

    cyc(1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    nxt();
    lu_in();
    nxt();
    for (int i = 0; i < 3; i++) begin
      busy(0);
      chk("frz_freeze", int'(fr[0]), 1);
      nxt();
    end
    idle();
    chk("frz_st1_bub", int'(bub[0]), 1);
    chk("frz_st1_fr", int'(fr[0]), 0);
    nxt();
    idle();
    chk("frz_st2_pc", int'(pc[0]), 0);
    nxt();
    idle();
    chk("frz_end_pc", int'(pc[0]), 1);
    chk("frz_sc0", int'(sc0), 6);
    chk("frz_sc1", int'(sc1), 4);
    nxt();

    cyc(1, 0, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    nxt();
    for (int i = 0; i < 20; i++) begin
      busy(0);
      nxt();
    end
    busy(1);
    chk("sat_sc0", int'(sc0), 15);
    chk("sat_sc1", int'(sc1), 20);
    nxt();
    idle();
    chk("clr_sc0", int'(sc0), 0);
    chk("clr_sc1", int'(sc1), 0);
    nxt();

    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(99) >= 2),
          ($urandom_range(99) < 15),
          ($urandom_range(99) < 15),
          ($urandom_range(1) == 1),
          (($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(3))),
          (($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(3))),
          4'($urandom_range(3)),
          ($urandom_range(1) == 1),
          ($urandom_range(1) == 1),
          ($urandom_range(99) < 2));
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage ARM pipeline. It watches the ID, EX and memory stages and sequences pipeline stalls, IF/ID flushes and full-pipeline freezes. It drives the bubble-select line of the control-unit mux: when that line is 1, the mux zeroes all ID-stage control signals. It also keeps saturating stall and flush performance counters.

## Interface
- LOAD_BUBBLES, 1: bubble cycles inserted per load-use hazard (legal 1–3).
- BRANCH_BUBBLES, 1: flush cycles per taken branch (legal 1–3).
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- id_rn  in  4  Rn field of the instruction in ID.
- id_rm  in  4  Rm field of the instruction in ID.
- id_uses_rn  in  1  the ID instruction reads Rn.
- id_uses_rm  in  1  the ID instruction reads Rm.
- ex_rd  in  4  destination register of the instruction in EX.
- ex_mem_read  in  1  the instruction in EX is a load.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipeline must hold.
- cnt_clear  in  1  synchronous clear of both counters.
- cu_bubble  out  1  bubble select to the control-unit mux (1 = zero all controls).
- pc_enable  out  1  PC register load enable.
- if_id_enable  out  1  IF/ID register load enable.
- if_id_flush  out  1  synchronous clear of IF/ID.
- pipe_freeze  out  1  hold enable for ID/EX, EX/MEM and MEM/WB (1 = hold).
- stall_count  out  CNT_WIDTH  cycles with pc_enable=0, saturating.
- flush_count  out  CNT_WIDTH  cycles with if_id_flush=1, saturating.

## Operation
- Registered state:
  - FSM: RUN, LU_STALL, BR_FLUSH.
  - Remaining-cycle counter cnt, 2 bits.
  - The two performance counters.
- Outputs are combinational from the state and the current inputs.
- Load-use hazard (lu) is 1 when all of the following hold:
  - ex_mem_read=1 and ex_rd≠4'hF;
  - (id_uses_rn and id_rn==ex_rd) or (id_uses_rm and id_rm==ex_rd).
  - R15 is never a hazard.
- Output modes:
  - NORMAL: pc_enable=1, if_id_enable=1, cu_bubble=0, if_id_flush=0, pipe_freeze=0.
  - FREEZE: pc_enable=0, if_id_enable=0, pipe_freeze=1, cu_bubble=0, if_id_flush=0.
  - STALL: pc_enable=0, if_id_enable=0, cu_bubble=1, if_id_flush=0, pipe_freeze=0.
  - FLUSH: pc_enable=1, if_id_enable=1, if_id_flush=1, cu_bubble=1, pipe_freeze=0.
- Per-cycle priority, any state: mem_busy > state action > branch_taken > lu.
  - mem_busy=1: FREEZE mode; state and cnt hold.
- RUN (mem_busy=0):
  - branch_taken=1: FLUSH mode. If BRANCH_BUBBLES>1, go to BR_FLUSH with cnt=BRANCH_BUBBLES-1; otherwise stay in RUN. lu is ignored this cycle.
  - else lu=1: STALL mode. If LOAD_BUBBLES>1, go to LU_STALL with cnt=LOAD_BUBBLES-1; otherwise stay in RUN.
  - else NORMAL mode.
- LU_STALL (mem_busy=0):
  - STALL mode; cnt decrements.
  - cnt==1 → RUN.
  - branch_taken and lu are not evaluated.
- BR_FLUSH (mem_busy=0):
  - FLUSH mode; cnt decrements.
  - cnt==1 → RUN.
  - branch_taken and lu are not evaluated.
- Counters:
  - stall_count increments in every cycle with pc_enable=0, including FREEZE cycles.
  - flush_count increments in every cycle with if_id_flush=1.
  - Both saturate at all-ones.
  - cnt_clear=1 zeroes both on the next edge and overrides any increment in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, cnt=0, stall_count=0, flush_count=0.
  - Outputs are forced to pc_enable=0, if_id_enable=0, cu_bubble=1, if_id_flush=0, pipe_freeze=0, regardless of the other inputs.
- Reset deasserted: NORMAL mode in the first cycle, unless a hazard input is active.
- Reset asserted mid LU_STALL or BR_FLUSH: the sequence is abandoned; there is no residual stall after release.
- Zero-cycle latency: hazard inputs affect the outputs in the same cycle. State changes land on the next rising clk edge.
- Load-use stall length: exactly LOAD_BUBBLES non-frozen cycles of STALL per hazard, plus any interleaved FREEZE cycles.
- Branch flush length: exactly BRANCH_BUBBLES non-frozen cycles of FLUSH per taken branch.
- Counter values are visible one cycle after the counted cycle.

## Test plan
- Reset mid-stall: LOAD_BUBBLES=3, trigger lu, pulse rst_n low in the 2nd stall cycle → outputs take their reset values immediately; after release, NORMAL mode with stall_count=0.
- Load-use: LOAD_BUBBLES=2; ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 for one cycle → cu_bubble=1 and pc_enable=0 for 2 cycles, then NORMAL; stall_count=2.
- No false hazard:
  - ex_rd=15 with id_rn=15 → NORMAL.
  - id_rm=ex_rd with id_uses_rm=0 → NORMAL.
- Branch beats load-use: BRANCH_BUBBLES=2; branch_taken=1 and lu=1 in the same cycle → if_id_flush=1, cu_bubble=1, pc_enable=1 for 2 cycles, no stall; flush_count=2, stall_count=0.
- Freeze inside a stall: LOAD_BUBBLES=3; mem_busy=1 for 3 cycles starting in the 2nd stall cycle → pipe_freeze=1 during those cycles, cnt held; 2 more STALL cycles follow; stall_count=6.
- Saturation and clear: CNT_WIDTH=4; mem_busy=1 for 20 cycles → stall_count=15 and holds. Then cnt_clear=1 in a cycle with mem_busy=1 → stall_count=0.
